// File: rtl/tone_bank.sv
// Bank of independent square-wave tone channels with per-channel duration timers,
// a shared millisecond prescaler and a small register interface.
module tone_bank #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned DUR_WIDTH    = 16,
    parameter int unsigned TICK_DIV     = 12000
) (
    input  logic                raw_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [7:0]          address,
    input  logic [31:0]         data_in,
    input  logic                write_enable,
    output logic [31:0]         data_out,
    output logic [CHANNELS-1:0] speaker_p,
    output logic [CHANNELS-1:0] speaker_m,
    output logic                irq
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] RegPeriod   = 2'd0;
    localparam logic [1:0] RegNote     = 2'd1;
    localparam logic [1:0] RegDuration = 2'd2;
    localparam logic [1:0] RegStatus   = 2'd3;

    // Periods for MIDI notes 60..96 at a 12 MHz clock, from the equal-tempered
    // frequency rounded to 0.01 Hz, i.e. floor(12e6 / f).
    function automatic logic [15:0] note_lookup(input logic [7:0] n);
        logic [15:0] p;
        case (n)
            8'd60: p = 16'd45866;
            8'd61: p = 16'd43293;
            8'd62: p = 16'd40863;
            8'd63: p = 16'd38569;
            8'd64: p = 16'd36404;
            8'd65: p = 16'd34361;
            8'd66: p = 16'd32433;
            8'd67: p = 16'd30612;
            8'd68: p = 16'd28894;
            8'd69: p = 16'd27272;
            8'd70: p = 16'd25742;
            8'd71: p = 16'd24297;
            8'd72: p = 16'd22933;
            8'd73: p = 16'd21646;
            8'd74: p = 16'd20431;
            8'd75: p = 16'd19284;
            8'd76: p = 16'd18202;
            8'd77: p = 16'd17180;
            8'd78: p = 16'd16216;
            8'd79: p = 16'd15306;
            8'd80: p = 16'd14447;
            8'd81: p = 16'd13636;
            8'd82: p = 16'd12870;
            8'd83: p = 16'd12148;
            8'd84: p = 16'd11466;
            8'd85: p = 16'd10823;
            8'd86: p = 16'd10215;
            8'd87: p = 16'd9642;
            8'd88: p = 16'd9101;
            8'd89: p = 16'd8590;
            8'd90: p = 16'd8108;
            8'd91: p = 16'd7653;
            8'd92: p = 16'd7223;
            8'd93: p = 16'd6818;
            8'd94: p = 16'd6435;
            8'd95: p = 16'd6074;
            8'd96: p = 16'd5733;
            default: p = 16'd0;
        endcase
        return p;
    endfunction

    // Bus decode
    logic [2:0] sel_ch;
    logic [1:0] sel_reg;
    logic       sel_ok;
    logic       wr_stb;
    logic       rd_stb;

    assign sel_ch  = address[6:4];
    assign sel_reg = address[3:2];
    assign sel_ok  = !address[7] && (32'(sel_ch) < CHANNELS);
    assign wr_stb  = enable && write_enable;
    assign rd_stb  = enable && !write_enable;

    // State
    logic [PreW-1:0]                        pre_q, pre_d;
    logic                                   tick;
    logic [CHANNELS-1:0][PERIOD_WIDTH-1:0]  period_q, period_d;
    logic [CHANNELS-1:0][PERIOD_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CHANNELS-1:0][DUR_WIDTH-1:0]     rem_q, rem_d;
    logic [CHANNELS-1:0]                    phase_q, phase_d;
    logic [CHANNELS-1:0]                    spk_p_q, spk_p_d;
    logic [CHANNELS-1:0]                    spk_m_q, spk_m_d;
    logic [CHANNELS-1:0]                    done_q, done_d;
    logic [31:0]                            rd_val;

    // Per-channel write strobes
    logic [CHANNELS-1:0] wr_period;
    logic [CHANNELS-1:0] wr_dur;
    logic [CHANNELS-1:0] wr_clr;
    logic [CHANNELS-1:0] expire;

    logic [31:0]             note_raw;
    logic                    note_fits;
    logic [PERIOD_WIDTH-1:0] period_load;

    always_comb begin
        note_raw    = {16'd0, note_lookup(data_in[7:0])};
        note_fits   = (note_raw >> PERIOD_WIDTH) == 32'd0;
        period_load = data_in[PERIOD_WIDTH-1:0];
        if (sel_reg == RegNote) begin
            period_load = note_fits ? note_raw[PERIOD_WIDTH-1:0] : '0;
        end
    end

    always_comb begin
        wr_period = '0;
        wr_dur    = '0;
        wr_clr    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_stb && sel_ok && (sel_ch == 3'(c))) begin
                wr_period[c] = (sel_reg == RegPeriod) || (sel_reg == RegNote);
                wr_dur[c]    = (sel_reg == RegDuration);
                wr_clr[c]    = (sel_reg == RegStatus) && data_in[1];
            end
        end
    end

    assign tick  = (pre_q == PreW'(TICK_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + PreW'(1);

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        phase_d  = phase_q;
        spk_p_d  = spk_p_q;
        spk_m_d  = spk_m_q;
        done_d   = done_q;
        expire   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            // Divider and output legs
            if (period_q[c] == '0) begin
                cnt_d[c]   = '0;
                spk_p_d[c] = 1'b0;
                spk_m_d[c] = 1'b0;
            end else if (cnt_q[c] == period_q[c]) begin
                cnt_d[c]   = '0;
                phase_d[c] = ~phase_q[c];
                spk_p_d[c] = phase_q[c];
                spk_m_d[c] = ~phase_q[c];
            end else begin
                cnt_d[c] = cnt_q[c] + PERIOD_WIDTH'(1);
            end

            // A DURATION write in the expiry cycle cancels the expiry outright.
            expire[c] = tick && (rem_q[c] == DUR_WIDTH'(1)) && !wr_dur[c];

            if (wr_period[c]) begin
                period_d[c] = period_load;
                cnt_d[c]    = '0;
                phase_d[c]  = 1'b0;
            end else if (expire[c]) begin
                period_d[c] = '0;
            end

            if (wr_dur[c]) begin
                rem_d[c] = data_in[DUR_WIDTH-1:0];
            end else if (tick && (rem_q[c] != '0)) begin
                rem_d[c] = rem_q[c] - DUR_WIDTH'(1);
            end

            if (expire[c]) begin
                done_d[c] = 1'b1;
            end else if (wr_clr[c]) begin
                done_d[c] = 1'b0;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel_ok && (sel_ch == 3'(c))) begin
                case (sel_reg)
                    RegPeriod:   rd_val = 32'(period_q[c]);
                    RegNote:     rd_val = '0;
                    RegDuration: rd_val = 32'(rem_q[c]);
                    RegStatus:   rd_val = {30'd0, done_q[c], period_q[c] != '0};
                    default:     rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            pre_q    <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            phase_q  <= '0;
            spk_p_q  <= '0;
            spk_m_q  <= '0;
            done_q   <= '0;
            data_out <= '0;
        end else begin
            pre_q    <= pre_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            phase_q  <= phase_d;
            spk_p_q  <= spk_p_d;
            spk_m_q  <= spk_m_d;
            done_q   <= done_d;
            if (rd_stb) begin
                data_out <= rd_val;
            end
        end
    end

    assign speaker_p = spk_p_q;
    assign speaker_m = spk_m_q;
    assign irq       = |done_q;

endmodule
